// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned multiply/divide unit. The 2*DATA_W-bit result goes back
// through the register file write port as two byte writes: low byte first, then high byte.
module muldiv_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic [ADDR_W-1:0] dest_lo,
    input  logic [ADDR_W-1:0] dest_hi,
    output logic              busy,
    output logic              done,
    output logic              wb_enable,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              div_by_zero
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WB_LO = 2'd2,
        WB_HI = 2'd3
    } state_t;

    state_t state, state_next;

    logic                op_q;
    logic [ADDR_W-1:0]   dest_lo_q;
    logic [ADDR_W-1:0]   dest_hi_q;
    logic [CNT_W-1:0]    count;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] mcand;
    logic [DATA_W-1:0]   mplier;
    logic [DATA_W-1:0]   divisor;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   quot;
    logic                dbz_q;

    logic                start_dbz;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_diff;
    logic                q_bit;
    logic [DATA_W-1:0]   rem_next;
    logic [DATA_W-1:0]   result_lo;
    logic [DATA_W-1:0]   result_hi;

    assign start_dbz = op && (operand_b == '0);

    // Restoring-division step: bring in the next dividend bit and subtract the divisor on trial
    always_comb begin
        div_shift = {rem, quot[DATA_W-1]};
        div_diff  = div_shift - {1'b0, divisor};
        q_bit     = ~div_diff[DATA_W];
        rem_next  = q_bit ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a divide by zero skips the iteration phase
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = start_dbz ? WB_LO : RUN;
                end
            end
            RUN: begin
                if (count == CNT_W'(1)) begin
                    state_next = WB_LO;
                end
            end
            WB_LO:   state_next = WB_HI;
            WB_HI:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand latch and one shift-add or restoring-divide iteration per RUN cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= 1'b0;
            dest_lo_q <= '0;
            dest_hi_q <= '0;
            count     <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            divisor   <= '0;
            rem       <= '0;
            quot      <= '0;
            dbz_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        dest_lo_q <= dest_lo;
                        dest_hi_q <= dest_hi;
                        count     <= CNT_W'(DATA_W);
                        dbz_q     <= start_dbz;
                        acc       <= '0;
                        mcand     <= (2*DATA_W)'(operand_a);
                        mplier    <= operand_b;
                        divisor   <= operand_b;
                        // Divide by zero: quotient saturates, dividend is returned as remainder
                        if (start_dbz) begin
                            quot <= '1;
                            rem  <= operand_a;
                        end else begin
                            quot <= operand_a;
                            rem  <= '0;
                        end
                    end
                end
                RUN: begin
                    count <= count - CNT_W'(1);
                    if (!op_q) begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end else begin
                        rem  <= rem_next;
                        quot <= {quot[DATA_W-2:0], q_bit};
                    end
                end
                default: ;
            endcase
        end
    end

    // Result byte selection from the latched operation type
    always_comb begin
        result_lo = op_q ? quot : acc[DATA_W-1:0];
        result_hi = op_q ? rem  : acc[2*DATA_W-1:DATA_W];
    end

    // Outputs decoded purely from registered state and latched data
    always_comb begin
        busy        = (state != IDLE);
        done        = 1'b0;
        wb_enable   = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        div_by_zero = dbz_q;
        case (state)
            WB_LO: begin
                wb_enable = 1'b1;
                wb_addr   = dest_lo_q;
                wb_data   = result_lo;
            end
            WB_HI: begin
                wb_enable = 1'b1;
                wb_addr   = dest_hi_q;
                wb_data   = result_hi;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with a small connected register file.
module tb_muldiv_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       op;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic [3:0] dest_lo;
    logic [3:0] dest_hi;
    logic       busy;
    logic       done;
    logic       wb_enable;
    logic [3:0] wb_addr;
    logic [7:0] wb_data;
    logic       div_by_zero;

    logic [7:0] regs [16];

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .dest_lo     (dest_lo),
        .dest_hi     (dest_hi),
        .busy        (busy),
        .done        (done),
        .wb_enable   (wb_enable),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Register file written by the unit's writeback port
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else if (wb_enable) begin
            regs[wb_addr] <= wb_data;
        end
    end

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic exp_dbz);
        check({tag, " busy"},  16'(busy), 16'd0);
        check({tag, " done"},  16'(done), 16'd0);
        check({tag, " wb_en"}, 16'(wb_enable), 16'd0);
        check({tag, " addr"},  16'(wb_addr), 16'd0);
        check({tag, " data"},  16'(wb_data), 16'd0);
        check({tag, " dbz"},   16'(div_by_zero), 16'(exp_dbz));
    endtask

    // Issue one operation from IDLE and check every cycle up to the return to IDLE.
    // pulse_at > 0 re-asserts start with different operands in that RUN cycle.
    task automatic do_op(input string tag, input logic t_op, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic [3:0] tdl, input logic [3:0] tdh,
                         input logic [7:0] exp_lo, input logic [7:0] exp_hi,
                         input logic exp_dbz, input int pulse_at);
        start     = 1'b1;
        op        = t_op;
        operand_a = ta;
        operand_b = tb_v;
        dest_lo   = tdl;
        dest_hi   = tdh;
        step();
        start     = 1'b0;
        operand_a = ~ta;
        operand_b = ~tb_v;
        dest_lo   = ~tdl;
        dest_hi   = ~tdh;
        if (!(t_op && tb_v == 8'd0)) begin
            for (int i = 1; i <= 8; i++) begin
                check({tag, " run busy"},  16'(busy), 16'd1);
                check({tag, " run wb_en"}, 16'(wb_enable), 16'd0);
                check({tag, " run dbz"},   16'(div_by_zero), 16'(exp_dbz));
                if (i == pulse_at) begin
                    start     = 1'b1;
                    op        = 1'b0;
                    operand_a = 8'd9;
                    operand_b = 8'd9;
                    dest_lo   = 4'd10;
                    dest_hi   = 4'd11;
                end else begin
                    start = 1'b0;
                end
                step();
            end
        end
        start = 1'b0;
        check({tag, " lo busy"},  16'(busy), 16'd1);
        check({tag, " lo wb_en"}, 16'(wb_enable), 16'd1);
        check({tag, " lo addr"},  16'(wb_addr), 16'(tdl));
        check({tag, " lo data"},  16'(wb_data), 16'(exp_lo));
        check({tag, " lo done"},  16'(done), 16'd0);
        check({tag, " lo dbz"},   16'(div_by_zero), 16'(exp_dbz));
        step();
        check({tag, " hi busy"},  16'(busy), 16'd1);
        check({tag, " hi wb_en"}, 16'(wb_enable), 16'd1);
        check({tag, " hi addr"},  16'(wb_addr), 16'(tdh));
        check({tag, " hi data"},  16'(wb_data), 16'(exp_hi));
        check({tag, " hi done"},  16'(done), 16'd1);
        step();
        check_idle({tag, " end"}, exp_dbz);
    endtask

    initial begin
        int pulses;
        reset     = 1'b1;
        start     = 1'b0;
        op        = 1'b0;
        operand_a = '0;
        operand_b = '0;
        dest_lo   = '0;
        dest_hi   = '0;
        step();
        step();
        check_idle("reset", 1'b0);
        reset = 1'b0;
        step();

        // 13*11 = 143
        do_op("mul13x11", 1'b0, 8'd13, 8'd11, 4'd2, 4'd3, 8'h8F, 8'h00, 1'b0, 0);
        // 255*255 = 0xFE01
        do_op("mulFFxFF", 1'b0, 8'hFF, 8'hFF, 4'd4, 4'd5, 8'h01, 8'hFE, 1'b0, 0);
        // 200/7 = 28 rem 4, written to R0/R1
        do_op("div200by7", 1'b1, 8'd200, 8'd7, 4'd0, 4'd1, 8'h1C, 8'h04, 1'b0, 0);
        // divide by zero: quotient 0xFF, remainder = dividend, flag sticky
        do_op("div0", 1'b1, 8'h5A, 8'h00, 4'd12, 4'd13, 8'hFF, 8'h5A, 1'b1, 0);
        step();
        check("dbz sticky", 16'(div_by_zero), 16'd1);
        // 3*4 = 12 with an ignored start at cycle 4; next accepted start clears the flag
        do_op("mul3x4", 1'b0, 8'd3, 8'd4, 4'd8, 4'd9, 8'h0C, 8'h00, 1'b0, 4);
        // back-to-back start in the IDLE cycle after done; both writes to R7
        do_op("mulsame", 1'b0, 8'h10, 8'h20, 4'd7, 4'd7, 8'h00, 8'h02, 1'b0, 0);

        check("R2", 16'(regs[2]), 16'h008F);
        check("R3", 16'(regs[3]), 16'h0000);
        check("R4", 16'(regs[4]), 16'h0001);
        check("R5", 16'(regs[5]), 16'h00FE);
        check("R0", 16'(regs[0]), 16'h001C);
        check("R1", 16'(regs[1]), 16'h0004);
        check("R12", 16'(regs[12]), 16'h00FF);
        check("R13", 16'(regs[13]), 16'h005A);
        check("R8", 16'(regs[8]), 16'h000C);
        check("R10 untouched", 16'(regs[10]), 16'h0000);
        check("R11 untouched", 16'(regs[11]), 16'h0000);
        check("R7", 16'(regs[7]), 16'h0002);

        // asynchronous reset in RUN cycle 5 aborts the operation
        start     = 1'b1;
        op        = 1'b0;
        operand_a = 8'd50;
        operand_b = 8'd3;
        dest_lo   = 4'd6;
        dest_hi   = 4'd6;
        step();
        start = 1'b0;
        repeat (4) step();
        check("pre-abort busy", 16'(busy), 16'd1);
        #2;
        reset = 1'b1;
        #1;
        check_idle("abort", 1'b0);
        step();
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (wb_enable || busy) pulses++;
        end
        check("no wb after abort", 16'(pulses), 16'd0);
        check("R6 after abort", 16'(regs[6]), 16'h0000);

        // unit accepts a new start after reset release
        do_op("post-reset", 1'b0, 8'd13, 8'd11, 4'd14, 4'd15, 8'h8F, 8'h00, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
